// File: rtl/uart_pkg.sv
// Shared UART definitions: parity selection, receiver FSM states and the
// clock-divider helper used by both the receive and transmit paths.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  // Number of system clocks per oversample tick (integer division).
  function automatic int calc_div(input int clk_freq, input int baud_rate,
                                  input int oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle tick every div clocks.
// A synchronous clear restarts the count so the tick phase can be aligned
// to an external event (e.g. a detected start edge).
module uart_baud_tick #(
  parameter int div = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (div > 1) ? $clog2(div) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(div - 1);

  logic [CW-1:0] cnt;

  // Divider counter: runs 0..div-1, restarts on clear or wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || (cnt == CNT_LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Tick on the wrap cycle; suppressed while being realigned.
  always_comb begin
    tick = (cnt == CNT_LAST) && !clear;
  end

endmodule

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver. The rx pin is synchronised, a falling edge
// starts a frame, and each bit is sampled once at its middle by counting
// oversample ticks. A completed frame is presented for one cycle on
// rx_data_vld together with its parity and framing status.
//
// Handshake: rx_data_vld is a one-cycle strobe with no back-pressure; the
// data and status outputs are updated on that cycle and hold until the next
// strobe, so a consumer may read them any time between strobes.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int clk_freq    = 50000000,
  parameter int baud_rate   = 19200,
  parameter int data_bits   = 8,
  parameter int parity_type = 0,
  parameter int stop_bits   = 1,
  parameter int oversample  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [data_bits-1:0] rx_data_out,
  output logic                 rx_data_vld,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 rx_busy
);

  localparam int DIV = calc_div(clk_freq, baud_rate, oversample);
  localparam int SW  = $clog2(oversample);

  localparam logic [SW-1:0] S_HALF  = SW'(oversample / 2 - 1);
  localparam logic [SW-1:0] S_LAST  = SW'(oversample - 1);
  localparam logic [3:0]    DB_LAST = 4'(data_bits - 1);
  localparam logic [3:0]    SB_LAST = 4'(stop_bits - 1);
  localparam bit            PAR_EN  = (parity_type != int'(PAR_NONE));
  localparam bit            PAR_ODD_CFG = (parity_type == int'(PAR_ODD));

  // Elaboration-time parameter range checks.
  if (DIV < 1) begin : g_div_chk
    $error("uart_rx_oversample: clk_freq/(baud_rate*oversample) must be >= 1");
  end
  if ((data_bits < 5) || (data_bits > 9)) begin : g_db_chk
    $error("uart_rx_oversample: data_bits must be 5..9");
  end
  if ((stop_bits < 1) || (stop_bits > 2)) begin : g_sb_chk
    $error("uart_rx_oversample: stop_bits must be 1..2");
  end
  if ((parity_type < 0) || (parity_type > 2)) begin : g_par_chk
    $error("uart_rx_oversample: parity_type must be 0, 1 or 2");
  end
  if ((oversample < 8) || ((oversample % 2) != 0)) begin : g_os_chk
    $error("uart_rx_oversample: oversample must be even and >= 8");
  end

  logic                 rx_meta;
  logic                 rx_s;
  rx_state_t            state_q;
  rx_state_t            state_d;
  logic                 tick;
  logic [SW-1:0]        s_cnt;
  logic [3:0]           bit_cnt;
  logic [data_bits-1:0] shreg;
  logic                 par_acc;
  logic                 fe_acc;
  logic                 armed;
  logic                 start_det;
  logic                 sample_pt;
  logic                 finish;

  // Two-flop synchroniser, preset to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Tick generator realigned to the start edge.
  uart_baud_tick #(
    .div(DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(start_det),
    .tick (tick)
  );

  // Start detection and mid-bit sample strobe (start bit is sampled half a
  // bit after the edge, every later bit one full bit after the previous).
  always_comb begin
    start_det = (state_q == IDLE) && armed && !rx_s;
    sample_pt = tick && (s_cnt == ((state_q == START) ? S_HALF : S_LAST));
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state and frame-complete strobe.
  always_comb begin
    state_d = state_q;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_det) state_d = START;
      end
      START: begin
        if (sample_pt) state_d = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (sample_pt && (bit_cnt == DB_LAST)) state_d = PAR_EN ? PARITY : STOP;
      end
      PARITY: begin
        if (sample_pt) state_d = STOP;
      end
      STOP: begin
        if (sample_pt && (bit_cnt == SB_LAST)) begin
          state_d = IDLE;
          finish  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sample-phase counter: cleared at the edge and at each sample point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_cnt <= '0;
    end else if (start_det || sample_pt) begin
      s_cnt <= '0;
    end else if (tick) begin
      s_cnt <= s_cnt + 1'b1;
    end
  end

  // Bits sampled within the current state; restarts on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (state_d != state_q) begin
      bit_cnt <= '0;
    end else if (sample_pt) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Data shift register (LSB arrives first) and per-frame error tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      par_acc <= 1'b0;
      fe_acc  <= 1'b0;
    end else if (start_det) begin
      shreg   <= '0;
      par_acc <= 1'b0;
      fe_acc  <= 1'b0;
    end else if (sample_pt) begin
      if (state_q == DATA) shreg <= {rx_s, shreg[data_bits-1:1]};
      if (state_q == PARITY) par_acc <= ((^shreg) ^ rx_s) != PAR_ODD_CFG;
      if ((state_q == STOP) && !rx_s) fe_acc <= 1'b1;
    end
  end

  // A stuck-low line must go high again before another start is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed <= 1'b1;
    end else if (finish) begin
      armed <= rx_s;
    end else if ((state_q == IDLE) && rx_s) begin
      armed <= 1'b1;
    end
  end

  // Output registers: word and status latched with the valid strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data_out <= '0;
      rx_data_vld <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      rx_busy     <= 1'b0;
    end else begin
      rx_data_vld <= finish;
      rx_busy     <= (state_d != IDLE);
      if (finish) begin
        rx_data_out <= shreg;
        parity_err  <= PAR_EN ? par_acc : 1'b0;
        framing_err <= fe_acc | ~rx_s;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Bench for uart_rx_oversample: three receivers (8N1, 8E1, 8N2) share clock
// and reset, each with its own serial line driven by frame-level tasks.
module tb_uart_rx_oversample;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 10000;
  localparam int OS       = 16;
  localparam int BIT_CLK  = CLK_FREQ / BAUD;

  logic       clk;
  logic       rst;
  logic [2:0] rx_l;
  logic [7:0] dout0, dout1, dout2;
  logic [2:0] vld, perr, ferr, busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [9:0] obs0[$], obs1[$], obs2[$];
  int         oc0[$], oc1[$], oc2[$];
  logic [9:0] exp_q[$];

  uart_rx_oversample #(.clk_freq(CLK_FREQ), .baud_rate(BAUD), .data_bits(8),
                       .parity_type(0), .stop_bits(1), .oversample(OS)) u_8n1 (
    .clk(clk), .rst(rst), .rx(rx_l[0]), .rx_data_out(dout0), .rx_data_vld(vld[0]),
    .parity_err(perr[0]), .framing_err(ferr[0]), .rx_busy(busy[0]));

  uart_rx_oversample #(.clk_freq(CLK_FREQ), .baud_rate(BAUD), .data_bits(8),
                       .parity_type(2), .stop_bits(1), .oversample(OS)) u_8e1 (
    .clk(clk), .rst(rst), .rx(rx_l[1]), .rx_data_out(dout1), .rx_data_vld(vld[1]),
    .parity_err(perr[1]), .framing_err(ferr[1]), .rx_busy(busy[1]));

  uart_rx_oversample #(.clk_freq(CLK_FREQ), .baud_rate(BAUD), .data_bits(8),
                       .parity_type(0), .stop_bits(2), .oversample(OS)) u_8n2 (
    .clk(clk), .rst(rst), .rx(rx_l[2]), .rx_data_out(dout2), .rx_data_vld(vld[2]),
    .parity_err(perr[2]), .framing_err(ferr[2]), .rx_busy(busy[2]));

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every valid strobe with its cycle number.
  always @(negedge clk) begin
    if (vld[0]) begin obs0.push_back({dout0, perr[0], ferr[0]}); oc0.push_back(cyc); end
    if (vld[1]) begin obs1.push_back({dout1, perr[1], ferr[1]}); oc1.push_back(cyc); end
    if (vld[2]) begin obs2.push_back({dout2, perr[2], ferr[2]}); oc2.push_back(cyc); end
  end

  // Watchdog.
  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Reference model: expected {data, parity_err, framing_err} for a frame.
  function automatic logic [9:0] model_frame(input logic [7:0] d, input bit par_en,
                                              input bit odd, input logic par_bit,
                                              input logic [1:0] stops, input int nstop);
    int  ones;
    bit  pe, fe;
    ones = $countones(d) + int'(par_bit);
    pe   = par_en && (((ones % 2) == 1) != odd);
    fe   = (stops[0] == 1'b0) || ((nstop == 2) && (stops[1] == 1'b0));
    return {d, pe, fe};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_rx(input int ch, input logic b);
    rx_l[ch] = b;
  endtask

  task automatic hold_bits(input int nclk);
    repeat (nclk) @(posedge clk);
  endtask

  task automatic send_frame(input int ch, input logic [7:0] d, input bit par_en,
                            input logic par_bit, input logic [1:0] stops,
                            input int nstop, output int t0);
    set_rx(ch, 1'b0);
    t0 = cyc;
    hold_bits(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      set_rx(ch, d[i]);
      hold_bits(BIT_CLK);
    end
    if (par_en) begin
      set_rx(ch, par_bit);
      hold_bits(BIT_CLK);
    end
    for (int i = 0; i < nstop; i++) begin
      set_rx(ch, stops[i]);
      hold_bits(BIT_CLK);
    end
    set_rx(ch, 1'b1);
  endtask

  task automatic clear_obs();
    obs0.delete(); obs1.delete(); obs2.delete();
    oc0.delete();  oc1.delete();  oc2.delete();
  endtask

  task automatic obs_size(input int ch, output int n);
    case (ch)
      0: n = obs0.size();
      1: n = obs1.size();
      default: n = obs2.size();
    endcase
  endtask

  // Fetch the next recorded strobe, waiting at most bound cycles.
  task automatic get_obs(input int ch, input int bound, output bit ok,
                         output logic [9:0] rec, output int vc);
    int n;
    ok = 1'b0; rec = '0; vc = 0;
    for (int i = 0; i <= bound; i++) begin
      obs_size(ch, n);
      if (n > 0) begin
        case (ch)
          0: begin rec = obs0.pop_front(); vc = oc0.pop_front(); end
          1: begin rec = obs1.pop_front(); vc = oc1.pop_front(); end
          default: begin rec = obs2.pop_front(); vc = oc2.pop_front(); end
        endcase
        ok = 1'b1;
        return;
      end
      @(posedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    rx_l = 3'b111;
    hold_bits(3);
    @(negedge clk);
    checks++;
    if ({dout0, dout1, dout2} !== 24'h0) begin
      failures++; $display("FAIL reset_data: got %h %h %h, need 0", dout0, dout1, dout2);
    end
    checks++;
    if ({vld, perr, ferr, busy} !== 12'h0) begin
      failures++; $display("FAIL reset_flags: vld=%b perr=%b ferr=%b busy=%b, need all 0",
                           vld, perr, ferr, busy);
    end
    rst = 1'b0;
    hold_bits(50);
    @(negedge clk);
    checks++;
    if ((obs0.size() + obs1.size() + obs2.size()) != 0 || busy !== 3'b000) begin
      failures++; $display("FAIL reset_idle: strobes=%0d busy=%b, need 0 and 000",
                           obs0.size() + obs1.size() + obs2.size(), busy);
    end
  endtask

  task automatic test_8n1_basic();
    int t0, vc; bit ok; logic [9:0] rec, e;
    clear_obs();
    e = model_frame(8'hA5, 1'b0, 1'b0, 1'b0, 2'b11, 1);
    send_frame(0, 8'hA5, 1'b0, 1'b0, 2'b11, 1, t0);
    get_obs(0, 300, ok, rec, vc);
    checks++;
    if (!ok || rec !== e) begin
      failures++; $display("FAIL 8n1_a5: ok=%0b got %h, need %h", ok, rec, e);
    end
    checks++;
    if (ok && ((vc - t0) < 1518 || (vc - t0) > 1528)) begin
      failures++; $display("FAIL 8n1_latency: got %0d cycles, need 1518..1528", vc - t0);
    end
    hold_bits(200);
    @(negedge clk);
    checks++;
    if (obs0.size() != 0 || dout0 !== 8'hA5 || busy[0] !== 1'b0 || vld[0] !== 1'b0) begin
      failures++; $display("FAIL 8n1_hold: extra=%0d data=%h busy=%b vld=%b, need 0 a5 0 0",
                           obs0.size(), dout0, busy[0], vld[0]);
    end
  endtask

  task automatic test_parity_8e1();
    int t0, vc; bit ok; logic [9:0] rec, e;
    clear_obs();
    e = model_frame(8'h03, 1'b1, 1'b0, 1'b0, 2'b11, 1);
    send_frame(1, 8'h03, 1'b1, 1'b0, 2'b11, 1, t0);
    get_obs(1, 300, ok, rec, vc);
    checks++;
    if (!ok || rec !== e) begin
      failures++; $display("FAIL 8e1_good_par: ok=%0b got %h, need %h", ok, rec, e);
    end
    hold_bits(BIT_CLK);
    e = model_frame(8'h03, 1'b1, 1'b0, 1'b1, 2'b11, 1);
    send_frame(1, 8'h03, 1'b1, 1'b1, 2'b11, 1, t0);
    get_obs(1, 300, ok, rec, vc);
    checks++;
    if (!ok || rec !== e) begin
      failures++; $display("FAIL 8e1_bad_par: ok=%0b got %h, need %h", ok, rec, e);
    end
    hold_bits(BIT_CLK);
  endtask

  task automatic test_false_start();
    int t0, vc, n; bit ok; logic [9:0] rec, e;
    clear_obs();
    set_rx(0, 1'b0);
    hold_bits(40);
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b1) begin
      failures++; $display("FAIL false_start_busy: got %b, need 1", busy[0]);
    end
    set_rx(0, 1'b1);
    hold_bits(2 * BIT_CLK);
    @(negedge clk);
    obs_size(0, n);
    checks++;
    if (n != 0 || busy[0] !== 1'b0) begin
      failures++; $display("FAIL false_start_quiet: strobes=%0d busy=%b, need 0 0", n, busy[0]);
    end
    e = model_frame(8'h5A, 1'b0, 1'b0, 1'b0, 2'b11, 1);
    send_frame(0, 8'h5A, 1'b0, 1'b0, 2'b11, 1, t0);
    get_obs(0, 300, ok, rec, vc);
    checks++;
    if (!ok || rec !== e) begin
      failures++; $display("FAIL false_start_next: ok=%0b got %h, need %h", ok, rec, e);
    end
    hold_bits(BIT_CLK);
  endtask

  task automatic test_framing();
    int t0, vc; bit ok; logic [9:0] rec, e;
    clear_obs();
    e = model_frame(8'h81, 1'b0, 1'b0, 1'b0, 2'b00, 1);
    send_frame(0, 8'h81, 1'b0, 1'b0, 2'b00, 1, t0);
    get_obs(0, 300, ok, rec, vc);
    checks++;
    if (!ok || rec !== e) begin
      failures++; $display("FAIL framing_bad_stop: ok=%0b got %h, need %h", ok, rec, e);
    end
    hold_bits(BIT_CLK);
    e = model_frame(8'h7E, 1'b0, 1'b0, 1'b0, 2'b11, 1);
    send_frame(0, 8'h7E, 1'b0, 1'b0, 2'b11, 1, t0);
    get_obs(0, 300, ok, rec, vc);
    checks++;
    if (!ok || rec !== e) begin
      failures++; $display("FAIL framing_recover: ok=%0b got %h, need %h", ok, rec, e);
    end
    hold_bits(BIT_CLK);
  endtask

  task automatic test_break();
    int t0, vc, n; bit ok; logic [9:0] rec, e;
    clear_obs();
    e = model_frame(8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 1);
    set_rx(0, 1'b0);
    hold_bits(20 * BIT_CLK);
    set_rx(0, 1'b1);
    hold_bits(2 * BIT_CLK);
    get_obs(0, 0, ok, rec, vc);
    obs_size(0, n);
    checks++;
    if (!ok || rec !== e || n != 0) begin
      failures++; $display("FAIL break_once: ok=%0b got %h extra=%0d, need %h and 0",
                           ok, rec, n, e);
    end
    e = model_frame(8'h33, 1'b0, 1'b0, 1'b0, 2'b11, 1);
    send_frame(0, 8'h33, 1'b0, 1'b0, 2'b11, 1, t0);
    get_obs(0, 300, ok, rec, vc);
    checks++;
    if (!ok || rec !== e) begin
      failures++; $display("FAIL break_recover: ok=%0b got %h, need %h", ok, rec, e);
    end
    hold_bits(BIT_CLK);
  endtask

  task automatic test_back_to_back();
    int t0, vc, n; bit ok; logic [9:0] rec, e0, e1;
    clear_obs();
    e0 = model_frame(8'h00, 1'b0, 1'b0, 1'b0, 2'b11, 2);
    e1 = model_frame(8'hFF, 1'b0, 1'b0, 1'b0, 2'b11, 2);
    send_frame(2, 8'h00, 1'b0, 1'b0, 2'b11, 2, t0);
    send_frame(2, 8'hFF, 1'b0, 1'b0, 2'b11, 2, t0);
    get_obs(2, 300, ok, rec, vc);
    checks++;
    if (!ok || rec !== e0) begin
      failures++; $display("FAIL b2b_first: ok=%0b got %h, need %h", ok, rec, e0);
    end
    get_obs(2, 300, ok, rec, vc);
    checks++;
    if (!ok || rec !== e1) begin
      failures++; $display("FAIL b2b_second: ok=%0b got %h, need %h", ok, rec, e1);
    end
    hold_bits(BIT_CLK);
    obs_size(2, n);
    checks++;
    if (n != 0) begin
      failures++; $display("FAIL b2b_count: got %0d extra strobes, need 0", n);
    end
  endtask

  task automatic test_reset_midframe();
    int t0, vc, n; bit ok; logic [9:0] rec, e;
    logic [7:0] d;
    clear_obs();
    d = 8'h5C;
    set_rx(0, 1'b0);
    hold_bits(BIT_CLK);
    for (int i = 0; i < 3; i++) begin
      set_rx(0, d[i]);
      hold_bits(BIT_CLK);
    end
    set_rx(0, d[3]);
    hold_bits(BIT_CLK / 2);
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b1) begin
      failures++; $display("FAIL midframe_busy: got %b, need 1", busy[0]);
    end
    rst = 1'b1;
    set_rx(0, 1'b1);
    #1;
    checks++;
    if (dout0 !== 8'h00 || {vld[0], perr[0], ferr[0], busy[0]} !== 4'b0000) begin
      failures++; $display("FAIL midframe_reset: data=%h flags=%b, need 00 0000",
                           dout0, {vld[0], perr[0], ferr[0], busy[0]});
    end
    hold_bits(3);
    rst = 1'b0;
    hold_bits(2 * BIT_CLK);
    obs_size(0, n);
    checks++;
    if (n != 0) begin
      failures++; $display("FAIL midframe_no_vld: got %0d strobes, need 0", n);
    end
    e = model_frame(8'hC3, 1'b0, 1'b0, 1'b0, 2'b11, 1);
    send_frame(0, 8'hC3, 1'b0, 1'b0, 2'b11, 1, t0);
    get_obs(0, 300, ok, rec, vc);
    checks++;
    if (!ok || rec !== e) begin
      failures++; $display("FAIL midframe_next: ok=%0b got %h, need %h", ok, rec, e);
    end
    hold_bits(BIT_CLK);
  endtask

  task automatic test_random_8e1();
    int t0, vc, gap, n; bit ok; logic [9:0] rec, e;
    logic [7:0] d; logic pb; logic [1:0] st;
    clear_obs();
    exp_q.delete();
    for (int k = 0; k < 16; k++) begin
      d  = 8'($urandom_range(0, 255));
      pb = ^d;
      if ($urandom_range(0, 3) == 0) pb = ~pb;
      st = ($urandom_range(0, 4) == 0) ? 2'b10 : 2'b11;
      exp_q.push_back(model_frame(d, 1'b1, 1'b0, pb, st, 1));
      send_frame(1, d, 1'b1, pb, st, 1, t0);
      gap = $urandom_range(0, 2);
      if (st[0] == 1'b0 && gap == 0) gap = 1;
      hold_bits(gap * BIT_CLK);
    end
    hold_bits(BIT_CLK);
    for (int k = 0; k < 16; k++) begin
      e = exp_q.pop_front();
      get_obs(1, 0, ok, rec, vc);
      checks++;
      if (!ok || rec !== e) begin
        failures++; $display("FAIL random_frame_%0d: ok=%0b got %h, need %h", k, ok, rec, e);
      end
    end
    obs_size(1, n);
    checks++;
    if (n != 0) begin
      failures++; $display("FAIL random_count: got %0d extra strobes, need 0", n);
    end
  endtask

  initial begin
    rst  = 1'b1;
    rx_l = 3'b111;
    test_reset();
    test_8n1_basic();
    test_parity_8e1();
    test_false_start();
    test_framing();
    test_break();
    test_back_to_back();
    test_reset_midframe();
    test_random_8e1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
